// File: rtl/program_loader.sv
// program_loader
// Boot-time loader sitting in front of the 15-bit-instruction core. It takes a
// program image as a byte stream (valid/ready), assembles HI/LO byte pairs into
// instruction words, writes them to instruction memory from address 0, and
// keeps the core stalled until the whole image is in place.
//
// Image format: length byte N (0 means 2^ADDR_W words), then N x {HI, LO},
// then, when PROGRAM_LOADER_CHECKSUM_EN is defined, one checksum byte equal to
// the XOR of every HI and LO byte.
//
// Optional feature macro: PROGRAM_LOADER_CHECKSUM_EN
//   defined   : CHK and ERR states exist and `error` reports a checksum mismatch
//   undefined : the last WRITE goes straight to RUN and `error` is tied to 0
//
// Ports
//   clk       system clock, rising edge
//   rst       asynchronous reset, active low
//   in_data   stream byte
//   in_valid  in_data is valid
//   in_ready  loader accepts a byte this cycle (state-derived only)
//   reload    one-cycle pulse: abort and restart loading from address 0
//   im_we     instruction memory write strobe
//   im_addr   instruction memory write address
//   im_data   instruction memory write data {opcode[14:8], literal[7:0]}
//   cpu_run   high lets the core fetch and execute
//   error     checksum failure, sticky until rst or reload
//
// state | meaning
// LEN   | waiting for the length byte
// HI    | waiting for the high byte of the next word
// LO    | waiting for the low byte of the next word
// WRITE | im_we asserted for one cycle, address advances
// CHK   | waiting for the checksum byte (checksum builds only)
// RUN   | image loaded, core released
// ERR   | checksum mismatch, core held (checksum builds only)
module program_loader #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               reload,
  output logic               im_we,
  output logic [ADDR_W-1:0]  im_addr,
  output logic [INSTR_W-1:0] im_data,
  output logic               cpu_run,
  output logic               error
);

  localparam int CNT_W = ADDR_W + 1;

  localparam logic [2:0] S_LEN   = 3'd0;
  localparam logic [2:0] S_HI    = 3'd1;
  localparam logic [2:0] S_LO    = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_RUN   = 3'd5;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CHK   = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd6;
`endif

  // Word count needs one extra bit so a length byte of 0 can mean 2^ADDR_W.
  localparam logic [CNT_W-1:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};

  logic [2:0]       state;
  logic [CNT_W-1:0] word_cnt;
  logic             xfer;
  logic             last_word;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]       chk_acc;
`endif

  assign xfer      = in_valid & in_ready;
  assign last_word = (word_cnt == CNT_W'(1));

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  assign in_ready = (state == S_LEN) || (state == S_HI) || (state == S_LO) ||
                    (state == S_CHK);
  assign error    = (state == S_ERR);
`else
  assign in_ready = (state == S_LEN) || (state == S_HI) || (state == S_LO);
  assign error    = 1'b0;
`endif
  assign im_we    = (state == S_WRITE);
  assign cpu_run  = (state == S_RUN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_LEN;
      word_cnt <= '0;
      im_addr  <= '0;
      im_data  <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      chk_acc  <= '0;
`endif
    end else if (reload) begin
      // reload outranks any byte transfer in the same cycle; a half-built
      // word is simply abandoned because WRITE is never reached for it.
      state   <= S_LEN;
      im_addr <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      chk_acc <= '0;
`endif
    end else begin
      case (state)
        S_LEN: begin
          if (xfer) begin
            word_cnt <= (in_data == 8'd0) ? MAX_WORDS : CNT_W'(in_data);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            chk_acc  <= '0;
`endif
            state    <= S_HI;
          end
        end
        S_HI: begin
          if (xfer) begin
            // Bit 7 of the high byte has no home in a 15-bit word.
            im_data[INSTR_W-1:8] <= in_data[INSTR_W-9:0];
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            chk_acc <= chk_acc ^ in_data;
`endif
            state <= S_LO;
          end
        end
        S_LO: begin
          if (xfer) begin
            im_data[7:0] <= in_data;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            chk_acc <= chk_acc ^ in_data;
`endif
            state <= S_WRITE;
          end
        end
        S_WRITE: begin
          im_addr  <= im_addr + ADDR_W'(1);
          word_cnt <= word_cnt - CNT_W'(1);
          if (!last_word) begin
            state <= S_HI;
          end else begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            state <= S_CHK;
`else
            state <= S_RUN;
`endif
          end
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (xfer) begin
            state <= (in_data == chk_acc) ? S_RUN : S_ERR;
          end
        end
`endif
        default: state <= state;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

  typedef logic [7:0] byte_q_t[$];

  logic        clk;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        reload;
  logic        im_we;
  logic [7:0]  im_addr;
  logic [14:0] im_data;
  logic        cpu_run;
  logic        error;

  int errors;
  int checks;

  logic [7:0]  log_addr[$];
  logic [14:0] log_data[$];

  program_loader #(.ADDR_W(8), .INSTR_W(15)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .reload   (reload),
    .im_we    (im_we),
    .im_addr  (im_addr),
    .im_data  (im_data),
    .cpu_run  (cpu_run),
    .error    (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory-side observer: records every write the memory would capture.
  always @(negedge clk) begin
    if (rst && im_we) begin
      log_addr.push_back(im_addr);
      log_data.push_back(im_data);
    end
  end

  task automatic apply_reset();
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    reload   = 1'b0;
    #12;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    log_addr.delete();
    log_data.delete();
  endtask

  // Presents bytes one per cycle (optionally every other cycle) and returns the
  // number of edges until cpu_run is seen, or -1 if the budget runs out.
  task automatic run_stream(input byte_q_t b, input bit toggle, input int max_cyc,
                            output int cyc_run, output int rdy_in_write,
                            output int rdy_dropped);
    int idx;
    int cyc;
    bit acc;
    idx = 0;
    cyc = 0;
    cyc_run = -1;
    rdy_in_write = 0;
    rdy_dropped = 0;
    while (cyc < max_cyc) begin
      if (idx < b.size()) begin
        in_valid = toggle ? (cyc % 2 == 0) : 1'b1;
        in_data  = b[idx];
      end else begin
        in_valid = 1'b0;
      end
      acc = in_valid && in_ready;
      if (im_we && in_ready) rdy_in_write++;
      if (!im_we && !cpu_run && !error && idx < b.size() && !in_ready) rdy_dropped++;
      @(posedge clk);
      #1;
      cyc++;
      if (acc) idx++;
      if (cpu_run) begin
        cyc_run = cyc;
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    reload   = 1'b0;
    #3;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (im_we !== 1'b0) begin errors++; $display("FAIL reset_im_we got %b want 0", im_we); end
    checks++; if (im_addr !== 8'h00) begin errors++; $display("FAIL reset_im_addr got %h want 00", im_addr); end
    checks++; if (im_data !== 15'h0000) begin errors++; $display("FAIL reset_im_data got %h want 0000", im_data); end
    checks++; if (cpu_run !== 1'b0) begin errors++; $display("FAIL reset_cpu_run got %b want 0", cpu_run); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error got %b want 0", error); end
    apply_reset();
  endtask

  task automatic test_basic_load(input bit toggle);
    byte_q_t b;
    int cr, rw, rd;
    int exp_cyc;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    b = '{8'h02, 8'h01, 8'h05, 8'h7F, 8'hAA, 8'hD1};
    exp_cyc = 8;
`else
    b = '{8'h02, 8'h01, 8'h05, 8'h7F, 8'hAA};
    exp_cyc = 7;
`endif
    apply_reset();
    run_stream(b, toggle, 60, cr, rw, rd);
    checks++; if (log_addr.size() != 2) begin errors++; $display("FAIL basic_write_count toggle=%0d got %0d want 2", toggle, log_addr.size()); end
    if (log_addr.size() == 2) begin
      checks++; if (log_addr[0] !== 8'h00 || log_data[0] !== 15'h0105) begin errors++; $display("FAIL basic_word0 got %h/%h want 00/0105", log_addr[0], log_data[0]); end
      checks++; if (log_addr[1] !== 8'h01 || log_data[1] !== 15'h7FAA) begin errors++; $display("FAIL basic_word1 got %h/%h want 01/7faa", log_addr[1], log_data[1]); end
    end
    checks++; if (rw != 0) begin errors++; $display("FAIL basic_ready_in_write got %0d cycles want 0", rw); end
    checks++; if (rd != 0) begin errors++; $display("FAIL basic_ready_dropped got %0d cycles want 0", rd); end
    if (!toggle) begin
      checks++; if (cr != exp_cyc) begin errors++; $display("FAIL basic_run_cycle got %0d want %0d", cr, exp_cyc); end
    end else begin
      checks++; if (cpu_run !== 1'b1) begin errors++; $display("FAIL toggle_cpu_run got %b want 1", cpu_run); end
    end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL basic_error got %b want 0", error); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL run_in_ready got %b want 0", in_ready); end
  endtask

  task automatic test_bit7_drop();
    byte_q_t b;
    int cr, rw, rd;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    b = '{8'h01, 8'hFF, 8'h00, 8'hFF};
`else
    b = '{8'h01, 8'hFF, 8'h00};
`endif
    apply_reset();
    run_stream(b, 1'b0, 30, cr, rw, rd);
    checks++; if (log_data.size() != 1) begin errors++; $display("FAIL bit7_write_count got %0d want 1", log_data.size()); end
    if (log_data.size() == 1) begin
      checks++; if (log_data[0] !== 15'h7F00) begin errors++; $display("FAIL bit7_data got %h want 7f00", log_data[0]); end
    end
    checks++; if (cpu_run !== 1'b1) begin errors++; $display("FAIL bit7_cpu_run got %b want 1", cpu_run); end
  endtask

  task automatic test_full_image();
    byte_q_t b;
    int cr, rw, rd;
    int bad;
    int exp_cyc;
    b.push_back(8'h00);
    for (int i = 0; i < 256; i++) begin
      b.push_back(8'(i));
      b.push_back(~8'(i));
    end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    b.push_back(8'h00);
    exp_cyc = 770;
`else
    exp_cyc = 769;
`endif
    apply_reset();
    run_stream(b, 1'b0, 1000, cr, rw, rd);
    checks++; if (log_addr.size() != 256) begin errors++; $display("FAIL full_write_count got %0d want 256", log_addr.size()); end
    bad = 0;
    for (int i = 0; i < log_addr.size() && i < 256; i++) begin
      if (log_addr[i] !== 8'(i) || log_data[i] !== {i[6:0], ~8'(i)}) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL full_write_contents got %0d bad words want 0", bad); end
    checks++; if (im_addr !== 8'h00) begin errors++; $display("FAIL full_addr_wrap got %h want 00", im_addr); end
    checks++; if (cr != exp_cyc) begin errors++; $display("FAIL full_run_cycle got %0d want %0d", cr, exp_cyc); end
  endtask

  task automatic test_reload();
    byte_q_t b;
    int cr, rw, rd;
    apply_reset();
    in_valid = 1'b1;
    in_data  = 8'h05;
    @(posedge clk); #1;
    in_data  = 8'h11;
    @(posedge clk); #1;
    // reload collides with a presented byte: the byte must be dropped
    reload   = 1'b1;
    in_data  = 8'h99;
    @(posedge clk); #1;
    reload   = 1'b0;
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b1 || im_we !== 1'b0) begin errors++; $display("FAIL reload_state got ready=%b we=%b want ready=1 we=0", in_ready, im_we); end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    b = '{8'h01, 8'h02, 8'h03, 8'h01};
`else
    b = '{8'h01, 8'h02, 8'h03};
`endif
    run_stream(b, 1'b0, 30, cr, rw, rd);
    checks++; if (log_addr.size() != 1) begin errors++; $display("FAIL reload_write_count got %0d want 1", log_addr.size()); end
    if (log_addr.size() == 1) begin
      checks++; if (log_addr[0] !== 8'h00 || log_data[0] !== 15'h0203) begin errors++; $display("FAIL reload_word got %h/%h want 00/0203", log_addr[0], log_data[0]); end
    end
    checks++; if (cpu_run !== 1'b1 || im_addr !== 8'h01) begin errors++; $display("FAIL reload_run got run=%b addr=%h want run=1 addr=01", cpu_run, im_addr); end
    // asynchronous reset while running
    #2;
    rst = 1'b0;
    #1;
    checks++; if (cpu_run !== 1'b0 || im_addr !== 8'h00 || in_ready !== 1'b1) begin errors++; $display("FAIL async_rst_run got run=%b addr=%h ready=%b want 0/00/1", cpu_run, im_addr, in_ready); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset_midload();
    apply_reset();
    in_valid = 1'b1;
    in_data  = 8'h02;
    @(posedge clk); #1;
    in_data  = 8'h7F;
    @(posedge clk); #1;
    in_data  = 8'h01;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (im_we !== 1'b1 || im_data !== 15'h7F01) begin errors++; $display("FAIL midload_write got we=%b data=%h want 1/7f01", im_we, im_data); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (im_we !== 1'b0 || im_data !== 15'h0000 || in_ready !== 1'b1 || cpu_run !== 1'b0) begin
      errors++; $display("FAIL midload_async_rst got we=%b data=%h ready=%b run=%b want 0/0000/1/0", im_we, im_data, in_ready, cpu_run);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    byte_q_t b;
    int cr, rw, rd;
    apply_reset();
    b = '{8'h01, 8'h01, 8'h05, 8'h04};
    run_stream(b, 1'b0, 30, cr, rw, rd);
    checks++; if (cr != 5) begin errors++; $display("FAIL chk_good_run_cycle got %0d want 5", cr); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL chk_good_error got %b want 0", error); end
    apply_reset();
    b = '{8'h01, 8'h01, 8'h05, 8'h05};
    run_stream(b, 1'b0, 20, cr, rw, rd);
    checks++; if (cr != -1 || cpu_run !== 1'b0) begin errors++; $display("FAIL chk_bad_run got cycle=%0d run=%b want -1/0", cr, cpu_run); end
    checks++; if (error !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL chk_bad_error got err=%b ready=%b want 1/0", error, in_ready); end
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
    checks++; if (error !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL chk_reload_clear got err=%b ready=%b want 0/1", error, in_ready); end
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    reload = 1'b0;
    test_reset();
    test_basic_load(1'b0);
    test_basic_load(1'b1);
    test_bit7_drop();
    test_full_image();
    test_reload();
    test_async_reset_midload();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time stage directly upstream of the 15-bit-instruction processor core. Receives a program as a byte stream over a valid/ready handshake, assembles two-byte instruction words, and writes them sequentially into instruction memory from address 0. Holds the core stalled (`cpu_run` low) until the whole image is written, then releases it. A `reload` pulse re-enters load mode without a reset.

## Interface

- `ADDR_W`, 8: instruction memory address width; sets the maximum image size of 2^ADDR_W words.
- `INSTR_W`, 15: instruction word width; opcode [14:8], literal [7:0].

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `reload`  in  1  single-cycle pulse; abort run and restart loading.
- `im_we`  out  1  instruction memory write strobe.
- `im_addr`  out  ADDR_W  write address.
- `im_data`  out  INSTR_W  write data.
- `cpu_run`  out  1  high means the core may fetch and execute; low holds the PC.
- `error`  out  1  checksum failure, sticky until `rst` or `reload`.

## Operation

- A byte is accepted on a rising edge where `in_valid & in_ready`. No transfer happens otherwise, and `in_data` is ignored.
- FSM states: LEN, HI, LO, WRITE, CHK, RUN, ERR.
- **LEN** (`in_ready` = 1): accept length byte N and latch word count = N. N = 0 means 2^ADDR_W words. Next state is HI.
- **HI** (`in_ready` = 1): accept the high byte and latch bits [6:0] as `im_data[14:8]`. Bit 7 is ignored. Next state is LO.
- **LO** (`in_ready` = 1): accept the low byte as `im_data[7:0]`. Next state is WRITE.
- **WRITE** (`in_ready` = 0):
  - `im_we` = 1 for exactly one cycle at the current `im_addr`.
  - On the next edge, `im_addr` increments (wraps at 2^ADDR_W) and the remaining-word count decrements.
  - If words remain, next state is HI. Otherwise next state is CHK when the checksum option is compiled in, else RUN.
- **CHK** (`in_ready` = 1): accept the checksum byte. A match goes to RUN; a mismatch goes to ERR.
- **RUN**: `cpu_run` = 1 and `in_ready` = 0. Stream bytes are not consumed.
- **ERR**: `error` = 1, `cpu_run` = 0, `in_ready` = 0.
- `reload` is sampled in every state. When seen:
  - next state is LEN;
  - `im_addr` becomes 0;
  - `error` clears;
  - `cpu_run` drops at that edge;
  - any partial word is discarded, and no write is issued for it.
  - `reload` in the same cycle as a byte transfer wins: the byte is dropped.
- Addresses beyond the image are left untouched; the loader never clears memory.

## Timing

- Reset values: state LEN, `in_ready` = 1, `im_we` = 0, `im_addr` = 0, `im_data` = 0, `cpu_run` = 0, `error` = 0, word count = 0, checksum accumulator = 0.
- `rst` asserted mid-load abandons the load immediately and asynchronously. Memory already written stays written.
- All outputs are registered or derived from state only. `in_ready` has no combinational path from `in_valid`.
- Write latency: `im_we` is high in the cycle after the LO byte is accepted.
- Throughput: at most one word per 3 cycles (HI, LO, WRITE).
- Minimum load time: 1 + 3N cycles, plus 1 if the checksum is enabled. `cpu_run` rises on the edge after the final WRITE (or after CHK).
- `im_addr` and `im_data` are stable throughout the `im_we` cycle. The memory captures them at the end of that cycle.

## Configuration

- `PROGRAM_LOADER_CHECKSUM_EN` defined:
  - CHK state exists.
  - Accumulator = XOR of all HI and LO bytes (full 8 bits, including the ignored bit 7). It excludes the length byte.
  - A mismatch enters ERR, and the core is never released.
- Not defined: CHK and ERR are removed, `error` is tied to 0, and the transition after the last WRITE goes straight to RUN.

## Test plan

- Reset, then stream N=2, bytes 0x01 0x05 0x7F 0xAA with `in_valid` held high:
  - writes (addr 0, 0x0105) and (addr 1, 0x7FAA);
  - `in_ready` is 0 during each WRITE;
  - `cpu_run` = 1 on cycle 7.
- Same image with `in_valid` toggled 1/0 every cycle: identical writes; `in_ready` never drops while waiting.
- High byte 0xFF, low byte 0x00: `im_data` = 0x7F00 (bit 7 dropped).
- N=0 with ADDR_W=8: 256 writes at addresses 0..255, `im_addr` wraps to 0, then `cpu_run` = 1.
- `reload` after HI is accepted, then a new image N=1 (0x02, 0x03):
  - no write for the aborted word;
  - a single write of (addr 0, 0x0203);
  - `rst` asserted mid-stream gives reset values asynchronously.
- With `PROGRAM_LOADER_CHECKSUM_EN`:
  - N=1, 0x01 0x05, checksum 0x04: `cpu_run` = 1.
  - Checksum 0x05 instead: `error` = 1, `cpu_run` stays 0, and `reload` clears `error`.
